// File: rtl/parity_frame_checker.sv
// Streaming parity checker. Each accepted word is checked against odd or even
// parity; words are grouped into frames with per-frame and lifetime error counts.
module parity_frame_checker #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int TOT_W     = 8,
  localparam int CNT_W    = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data,
  input  logic              parity,
  input  logic              trig,
  input  logic              clr,
  output logic              word_err_vld,
  output logic              word_err,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_err_cnt,
  output logic              sticky_err,
  output logic [TOT_W-1:0]  tot_err
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN);

  state_t           state;
  logic             mode;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] err_acc;

  logic             accept;
  logic             mode_now;
  logic             word_fail;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] err_next;

  // The first word of a frame is checked with the live trig; later words use
  // the value latched when that first word was accepted.
  always_comb begin
    accept     = in_valid & in_ready;
    mode_now   = (state == IDLE) ? trig : mode;
    word_fail  = mode_now ? (^{data, parity}) : ~(^{data, parity});
    count_next = count + CNT_W'(1);
    err_next   = err_acc + CNT_W'(word_fail);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mode          <= 1'b0;
      count         <= '0;
      err_acc       <= '0;
      in_ready      <= 1'b1;
      word_err_vld  <= 1'b0;
      word_err      <= 1'b0;
      frame_done    <= 1'b0;
      frame_err_cnt <= '0;
      sticky_err    <= 1'b0;
      tot_err       <= '0;
    end else begin
      word_err_vld <= accept;
      frame_done   <= 1'b0;
      if (accept) word_err <= word_fail;

      case (state)
        IDLE, ACC: begin
          if (accept) begin
            if (state == IDLE) mode <= trig;
            count   <= count_next;
            err_acc <= err_next;
            if (count_next == LAST) begin
              state         <= DONE;
              in_ready      <= 1'b0;
              frame_done    <= 1'b1;
              frame_err_cnt <= err_next;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          count    <= '0;
          err_acc  <= '0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          count    <= '0;
          err_acc  <= '0;
        end
      endcase

      // clr wins over a failure arriving on the same edge.
      if (clr) begin
        sticky_err <= 1'b0;
        tot_err    <= '0;
      end else if (accept && word_fail) begin
        sticky_err <= 1'b1;
        if (tot_err != {TOT_W{1'b1}}) tot_err <= tot_err + TOT_W'(1);
      end
    end
  end

endmodule
